// File: rtl/execute_hazard_controller.sv
// -----------------------------------------------------------------------------
// execute_hazard_controller
//   Hazard and forwarding control for the Execute stage. Keeps a shadow copy of
//   the register usage of the instructions in EX, EX/MEM and MEM/WB, and from it
//   derives the EX operand-forwarding selects, a one-cycle load-use stall and a
//   multi-cycle flush after a taken branch. Owns no datapath.
//
// Parameters
//   REG_AW        register-address width
//   FLUSH_CYCLES  cycles flush is high after a taken branch (>= 1)
//
// Ports
//   clk, rst           clock, asynchronous active-low reset
//   id_*               decoded register usage of the instruction in ID
//   ex_branch_taken    taken branch resolved in EX
//   forward1_sel/2_sel 00 register file, 01 EX/MEM, 10 MEM/WB
//   stall              hold PC and IF/ID, bubble into EX
//   flush              squash IF/ID and ID/EX
//   pc_write           PC enable
// -----------------------------------------------------------------------------
module execute_hazard_controller #(
  parameter int REG_AW       = 3,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_src1,
  input  logic [REG_AW-1:0] id_src2,
  input  logic              id_use_src1,
  input  logic              id_use_src2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              ex_branch_taken,
  output logic [1:0]        forward1_sel,
  output logic [1:0]        forward2_sel,
  output logic              stall,
  output logic              flush,
  output logic              pc_write
);

  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);
  // The branch cycle itself is the first flush cycle, so the FLUSH state only
  // has to cover the remaining FLUSH_CYCLES-1 cycles.
  localparam logic [CNT_W-1:0] CNT_LOAD =
    CNT_W'((FLUSH_CYCLES > 1) ? (FLUSH_CYCLES - 2) : 0);
  localparam bit MULTI_CYCLE = (FLUSH_CYCLES > 1);

  typedef enum logic {S_RUN, S_FLUSH} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // EX slot shadow
  logic              ex_valid, ex_use1, ex_use2, ex_wr, ex_mr;
  logic [REG_AW-1:0] ex_src1, ex_src2, ex_rd;
  // EX/MEM and MEM/WB shadows
  logic              em_valid, em_wr, mw_valid, mw_wr;
  logic [REG_AW-1:0] em_rd, mw_rd;

  logic branch_now;

  assign branch_now = (state == S_RUN) && ex_branch_taken && ex_valid;
  assign flush      = branch_now || (state == S_FLUSH);

  // Load-use: the consumer in ID needs a value the load in EX has not fetched.
  // A flush squashes the consumer anyway, so it overrides the stall.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    stall = 1'b0;
    if (id_valid && ex_valid && ex_mr && ex_wr && !flush)
      stall = (id_use_src1 && (id_src1 == ex_rd)) ||
              (id_use_src2 && (id_src2 == ex_rd));
  end

  assign pc_write = rst && !stall;

  // EX/MEM is checked first: it holds the youngest producer of the register.
  function automatic logic [1:0] fwd_sel(input logic use_src,
                                         input logic [REG_AW-1:0] src);
    if (ex_valid && use_src && em_valid && em_wr && (em_rd == src))
      return 2'b01;
    else if (ex_valid && use_src && mw_valid && mw_wr && (mw_rd == src))
      return 2'b10;
    else
      return 2'b00;
  endfunction

  assign forward1_sel = fwd_sel(ex_use1, ex_src1);
  assign forward2_sel = fwd_sel(ex_use2, ex_src2);

  // Pipeline shadow. Stall and flush both load a bubble into EX while the older
  // stages keep draining.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: all tracking state is cleared so no stale destination can forward
    // after reset; only the valid bits strictly need it, the rest is cheap.
    if (!rst) begin
      ex_valid <= 1'b0;
      ex_use1  <= 1'b0;
      ex_use2  <= 1'b0;
      ex_wr    <= 1'b0;
      ex_mr    <= 1'b0;
      ex_src1  <= '0;
      ex_src2  <= '0;
      ex_rd    <= '0;
      em_valid <= 1'b0;
      em_wr    <= 1'b0;
      em_rd    <= '0;
      mw_valid <= 1'b0;
      mw_wr    <= 1'b0;
      mw_rd    <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample the old value of
      // its predecessor, so the shift happens in one edge regardless of order.
      mw_valid <= em_valid;
      mw_wr    <= em_wr;
      mw_rd    <= em_rd;
      em_valid <= ex_valid;
      em_wr    <= ex_wr;
      em_rd    <= ex_rd;
      ex_valid <= id_valid && !stall && !flush;
      ex_use1  <= id_use_src1;
      ex_use2  <= id_use_src2;
      ex_wr    <= id_reg_write;
      ex_mr    <= id_mem_read;
      ex_src1  <= id_src1;
      ex_src2  <= id_src2;
      ex_rd    <= id_rd;
    end
  end

  // Flush sequencer. Branch inputs are ignored in S_FLUSH since EX only holds
  // bubbles there.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_RUN;
      cnt   <= '0;
    end else begin
      case (state)
        S_RUN: begin
          if (branch_now && MULTI_CYCLE) begin
            state <= S_FLUSH;
            cnt   <= CNT_LOAD;
          end
        end
        S_FLUSH: begin
          if (cnt == '0) state <= S_RUN;
          else           cnt   <= cnt - CNT_W'(1);
        end
        default: state <= S_RUN;
      endcase
    end
  end

endmodule
